// File: rtl/regfile_context_unit_pkg.sv
// rtl/regfile_context_unit_pkg.sv - shared CPU constants and context-sequencer state type
package regfile_context_unit_pkg;

    localparam int DATA_W    = 16;
    localparam int NREG      = 8;
    localparam int REG_IDX_W = 3;

    // Register file layout: BA, three address registers, four data registers.
    localparam logic [REG_IDX_W-1:0] REG_BA = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_A1 = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_A2 = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_A3 = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_D0 = 3'd4;
    localparam logic [REG_IDX_W-1:0] REG_D1 = 3'd5;
    localparam logic [REG_IDX_W-1:0] REG_D2 = 3'd6;
    localparam logic [REG_IDX_W-1:0] REG_D3 = 3'd7;

    typedef enum logic [2:0] {
        CTX_IDLE     = 3'd0,
        CTX_SAVE     = 3'd1,
        CTX_LOAD_REQ = 3'd2,
        CTX_LOAD_WB  = 3'd3,
        CTX_DONE     = 3'd4
    } ctx_state_t;

endpackage

// File: rtl/regfile_context_unit.sv
// rtl/regfile_context_unit.sv - bulk save/restore of the CPU register file to data memory
module regfile_context_unit
    import regfile_context_unit_pkg::*;
#(
    parameter int DATA_W = regfile_context_unit_pkg::DATA_W,
    parameter int NREG   = regfile_context_unit_pkg::NREG,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      save_req,
    input  logic                      restore_req,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREG)-1:0]   rf_read_addr,
    input  logic [DATA_W-1:0]         rf_read_data,
    output logic [$clog2(NREG)-1:0]   rf_write_addr,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack
);

    localparam int IDX_W = $clog2(NREG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

    ctx_state_t          state;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   cur_addr;

    // Wraps modulo 2^ADDR_W by construction of the adder width.
    assign cur_addr = base_q + {{(ADDR_W-IDX_W){1'b0}}, idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CTX_IDLE;
            idx    <= '0;
            base_q <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                CTX_IDLE: begin
                    if (save_req) begin
                        state  <= CTX_SAVE;
                        base_q <= base_addr;
                        idx    <= '0;
                    end else if (restore_req) begin
                        state  <= CTX_LOAD_REQ;
                        base_q <= base_addr;
                        idx    <= '0;
                    end
                end
                CTX_SAVE: begin
                    if (mem_ack) begin
                        if (idx == LAST_IDX) state <= CTX_DONE;
                        else                 idx   <= idx + 1'b1;
                    end
                end
                CTX_LOAD_REQ: begin
                    if (mem_ack) begin
                        rd_q  <= mem_rdata;
                        state <= CTX_LOAD_WB;
                    end
                end
                CTX_LOAD_WB: begin
                    if (idx == LAST_IDX) begin
                        state <= CTX_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= CTX_LOAD_REQ;
                    end
                end
                CTX_DONE: begin
                    state <= CTX_IDLE;
                    idx   <= '0;
                end
                default: state <= CTX_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register; everything idles at zero.
    always_comb begin
        busy          = (state != CTX_IDLE);
        done          = (state == CTX_DONE);
        rf_read_addr  = '0;
        rf_write_addr = '0;
        rf_write_data = '0;
        rf_write_en   = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        case (state)
            CTX_SAVE: begin
                rf_read_addr = idx;
                mem_addr     = cur_addr;
                mem_wdata    = rf_read_data;
                mem_we       = 1'b1;
            end
            CTX_LOAD_REQ: begin
                mem_addr = cur_addr;
                mem_re   = 1'b1;
            end
            CTX_LOAD_WB: begin
                rf_write_en   = 1'b1;
                rf_write_addr = idx;
                rf_write_data = rd_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_context_unit.sv
// tb/tb_regfile_context_unit.sv - directed self-checking bench for regfile_context_unit
module tb_regfile_context_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        save_req;
    logic        restore_req;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic [2:0]  rf_read_addr;
    logic [15:0] rf_read_data;
    logic [2:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic        rf_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];
    logic [15:0] wlog [$];
    int          lat = 0;
    int          wait_cnt = 0;
    int          wpulses = 0;
    int          re_cycles = 0;

    int n_cmp = 0;
    int n_err = 0;

    regfile_context_unit dut (
        .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
        .base_addr(base_addr), .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_en(rf_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];
    assign mem_rdata    = mem[mem_addr];
    assign mem_ack      = (mem_we || mem_re) && (wait_cnt == lat);

    // Register file and memory models; reset restores CPU power-up values and the restore image.
    always @(posedge clk) begin
        if (rst) begin
            rf[0] <= 16'h0400; rf[1] <= 16'h4444; rf[2] <= 16'h4443; rf[3] <= 16'h4000;
            rf[4] <= 16'h0000; rf[5] <= 16'h0000; rf[6] <= 16'hFFFD; rf[7] <= 16'h0000;
            for (int i = 0; i < 8; i++) mem[16'h0300 + i] <= 16'(16'h1111 * (i + 1));
        end else if (rf_write_en) begin
            rf[rf_write_addr] <= rf_write_data;
        end
        if (rf_write_en) wpulses <= wpulses + 1;
        if (mem_re) re_cycles <= re_cycles + 1;
        if ((mem_we || mem_re) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                                wait_cnt <= 0;
        if (mem_we && mem_ack) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one start request and return the cycle (1 = first cycle after the start edge) of done.
    task automatic do_xfer(input logic sv, input logic rs, input logic [15:0] base,
                           input int inject_rs_at, output int done_cyc);
        int n;
        @(negedge clk);
        save_req = sv; restore_req = rs; base_addr = base;
        @(negedge clk);
        save_req = 1'b0; restore_req = 1'b0; base_addr = 16'h0000;
        done_cyc = -1;
        n = 1;
        while (n <= 400) begin
            restore_req = (n == inject_rs_at);
            if (done) begin
                done_cyc = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        restore_req = 1'b0;
        @(negedge clk);
    endtask

    int dc;
    int snap_log;
    int snap_wp;
    int snap_re;
    int guard;
    logic [15:0] save_exp [0:7];

    initial begin
        save_exp[0] = 16'h0400; save_exp[1] = 16'h4444; save_exp[2] = 16'h4443; save_exp[3] = 16'h4000;
        save_exp[4] = 16'h0000; save_exp[5] = 16'h0000; save_exp[6] = 16'hFFFD; save_exp[7] = 16'h0000;
        rst = 1'b1; save_req = 1'b0; restore_req = 1'b0; base_addr = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,        1'b0);
        check("rst_done",   done,        1'b0);
        check("rst_we",     mem_we,      1'b0);
        check("rst_re",     mem_re,      1'b0);
        check("rst_rfwe",   rf_write_en, 1'b0);
        check("rst_addr",   mem_addr,    16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Save with same-cycle ack of the power-up register file.
        lat = 0;
        do_xfer(1'b1, 1'b0, 16'h0200, -1, dc);
        check("save_done_cyc", dc, 9);
        check("save_busy_after", busy, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("save_mem%0d", i), mem[16'h0200 + i], save_exp[i]);

        // Restore with two wait cycles per read.
        lat = 2;
        snap_wp = wpulses;
        do_xfer(1'b0, 1'b1, 16'h0300, -1, dc);
        check("rest_done_cyc", dc, 33);
        check("rest_wpulses", wpulses - snap_wp, 8);
        for (int i = 0; i < 8; i++) check($sformatf("rest_rf%0d", i), rf[i], 16'(16'h1111 * (i + 1)));

        // Simultaneous requests: save wins.
        lat = 1;
        snap_re = re_cycles;
        do_xfer(1'b1, 1'b1, 16'h0400, -1, dc);
        check("both_done_cyc", dc, 17);
        check("both_no_re", re_cycles - snap_re, 0);
        check("both_mem0", mem[16'h0400], 16'h1111);
        check("both_mem7", mem[16'h0407], 16'h8888);

        // Address wrap at the top of memory.
        lat = 0;
        snap_log = wlog.size();
        do_xfer(1'b1, 1'b0, 16'hFFFE, -1, dc);
        check("wrap_count", wlog.size() - snap_log, 8);
        for (int i = 0; i < 8; i++)
            if (snap_log + i < wlog.size())
                check($sformatf("wrap_addr%0d", i), wlog[snap_log + i], 16'(16'hFFFE + i));

        // Reset after the third ack of a save.
        lat = 2;
        snap_log = wlog.size();
        @(negedge clk);
        save_req = 1'b1; base_addr = 16'h0500;
        @(negedge clk);
        save_req = 1'b0;
        guard = 0;
        while (wlog.size() < snap_log + 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reached3", wlog.size() - snap_log, 3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1'b0);
        check("mid_we", mem_we, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_more_wr", wlog.size() - snap_log, 3);
        lat = 0;
        snap_log = wlog.size();
        do_xfer(1'b1, 1'b0, 16'h0600, -1, dc);
        check("mid_restart_addr", (wlog.size() > snap_log) ? wlog[snap_log] : 16'hDEAD, 16'h0600);
        check("mid_restart_r0", mem[16'h0600], 16'h0400);

        // Restore request while save busy is dropped.
        snap_re = re_cycles;
        do_xfer(1'b1, 1'b0, 16'h0700, 3, dc);
        check("ign_done_cyc", dc, 9);
        repeat (10) @(negedge clk);
        check("ign_no_re", re_cycles - snap_re, 0);
        check("ign_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
